// File: rtl/rlp_pkg.sv
// Shared types and constants for the raster scan controller.
// Holds the line sequencer state encoding and default geometry.
package rlp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FACET,
        DELAY,
        ACTIVE,
        DRAIN,
        LINE_END
    } state_t;

    localparam int FB_ADDR_W     = 19;
    localparam int PIX_W         = 8;
    localparam int LINE_W        = 9;
    localparam int H_PIXELS_DEF  = 640;
    localparam int V_LINES_DEF   = 480;

endpackage

// File: rtl/rsc_read_pipe.sv
// Tracks in-flight framebuffer reads and registers returned pixels
// onto the laser intensity output; blanks on command.
module rsc_read_pipe #(
    parameter int READ_LATENCY = 1,
    parameter int DATA_W       = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_issue,
    input  logic              i_blank,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_pixel,
    output logic              o_active
);

    logic [READ_LATENCY-1:0] r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid  <= '0;
            o_pixel  <= '0;
            o_active <= 1'b0;
        end else begin
            r_valid[0] <= i_issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
            // Pixel is held until the next return or the line blanks
            if (i_blank) begin
                o_pixel  <= '0;
                o_active <= 1'b0;
            end else if (r_valid[READ_LATENCY-1]) begin
                o_pixel  <= i_rdata;
                o_active <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/raster_scan_controller.sv
// Line-by-line framebuffer readout paced by facet pulses and pixel ticks,
// driving laser intensity and stepping the vertical galvo per line.
module raster_scan_controller
    import rlp_pkg::*;
#(
    parameter int H_PIXELS     = H_PIXELS_DEF,
    parameter int V_LINES      = V_LINES_DEF,
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int DATA_W       = PIX_W,
    parameter int START_DELAY  = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              enable,
    input  logic              facet_pulse,
    input  logic              pixel_tick,
    input  logic              clear_overrun,
    output logic [ADDR_W-1:0] fb_address,
    output logic              fb_chipselect,
    output logic              fb_clken,
    output logic              fb_write,
    output logic [DATA_W-1:0] fb_writedata,
    input  logic [DATA_W-1:0] fb_readdata,
    output logic [DATA_W-1:0] laser_intensity,
    output logic              laser_active,
    output logic [8:0]        line_index,
    output logic              galvo_step,
    output logic              galvo_home,
    output logic              frame_done,
    output logic              line_overrun,
    output logic              busy
);

    localparam int X_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int C_W = 16;

    state_t            r_state;
    logic [X_W-1:0]    r_x;
    logic [LINE_W-1:0] r_y;
    logic [ADDR_W-1:0] r_addr;
    logic [C_W-1:0]    r_cnt;
    logic              w_blank;
    logic              w_last_line;

    assign fb_clken     = 1'b1;
    assign fb_write     = 1'b0;
    assign fb_writedata = '0;
    assign line_index   = r_y;
    assign busy         = (r_state != IDLE);
    assign w_blank      = (r_state == LINE_END);
    assign w_last_line  = (r_y == LINE_W'(V_LINES - 1));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state       <= IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_addr        <= '0;
            r_cnt         <= '0;
            fb_address    <= '0;
            fb_chipselect <= 1'b0;
            galvo_step    <= 1'b0;
            galvo_home    <= 1'b0;
            frame_done    <= 1'b0;
            line_overrun  <= 1'b0;
        end else begin
            fb_chipselect <= 1'b0;
            galvo_step    <= 1'b0;
            galvo_home    <= 1'b0;
            frame_done    <= 1'b0;
            if (clear_overrun) begin
                line_overrun <= 1'b0;
            end
            // A facet arriving mid-line means the line rate is too slow
            if (facet_pulse && (r_state inside {DELAY, ACTIVE, DRAIN})) begin
                line_overrun <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    r_x    <= '0;
                    r_y    <= '0;
                    r_addr <= '0;
                    if (enable) begin
                        r_state <= WAIT_FACET;
                    end
                end
                WAIT_FACET: begin
                    if (!enable) begin
                        r_y     <= '0;
                        r_addr  <= '0;
                        r_state <= IDLE;
                    end else if (facet_pulse) begin
                        r_cnt   <= '0;
                        r_state <= (START_DELAY == 0) ? ACTIVE : DELAY;
                    end
                end
                DELAY: begin
                    if (pixel_tick) begin
                        if (r_cnt == C_W'(START_DELAY - 1)) begin
                            r_cnt   <= '0;
                            r_state <= ACTIVE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (pixel_tick) begin
                        fb_address    <= r_addr;
                        fb_chipselect <= 1'b1;
                        r_addr        <= r_addr + 1'b1;
                        if (r_x == X_W'(H_PIXELS - 1)) begin
                            r_cnt   <= '0;
                            r_state <= DRAIN;
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (r_cnt == C_W'(READ_LATENCY)) begin
                        r_state    <= LINE_END;
                        galvo_step <= 1'b1;
                        galvo_home <= w_last_line;
                        frame_done <= w_last_line;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                LINE_END: begin
                    r_x <= '0;
                    if (w_last_line || !enable) begin
                        r_y    <= '0;
                        r_addr <= '0;
                    end else begin
                        r_y <= r_y + 1'b1;
                    end
                    r_state <= enable ? WAIT_FACET : IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    rsc_read_pipe #(
        .READ_LATENCY (READ_LATENCY),
        .DATA_W       (DATA_W)
    ) u_read_pipe (
        .i_clk    (clk_clk),
        .i_rst_n  (reset_reset_n),
        .i_issue  (fb_chipselect),
        .i_blank  (w_blank),
        .i_rdata  (fb_readdata),
        .o_pixel  (laser_intensity),
        .o_active (laser_active)
    );

endmodule

// File: tb/tb_raster_scan_controller.sv
// Scoreboard bench: expected reads queued as ticks are driven,
// popped when chipselect and returned intensity appear.
module tb_raster_scan_controller;

    typedef struct {
        int a;
        int e;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic facet = 1'b0;
    logic tick = 1'b0;
    logic clr = 1'b0;
    logic sel = 1'b0;

    logic [18:0] a1, a0;
    logic        cs1, cs0, ck1, ck0, wr1, wr0;
    logic [7:0]  wd1, wd0, li1, li0;
    logic [7:0]  rd1 = 8'h00;
    logic [7:0]  rd0 = 8'h00;
    logic        la1, la0, gs1, gs0, gh1, gh0, fd1, fd0;
    logic        ov1, ov0, bz1, bz0;
    logic [8:0]  ln1, ln0;

    raster_scan_controller #(
        .H_PIXELS(4), .V_LINES(3), .ADDR_W(19), .DATA_W(8),
        .START_DELAY(2), .READ_LATENCY(1)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable),
        .facet_pulse(facet), .pixel_tick(tick), .clear_overrun(clr),
        .fb_address(a1), .fb_chipselect(cs1), .fb_clken(ck1),
        .fb_write(wr1), .fb_writedata(wd1), .fb_readdata(rd1),
        .laser_intensity(li1), .laser_active(la1), .line_index(ln1),
        .galvo_step(gs1), .galvo_home(gh1), .frame_done(fd1),
        .line_overrun(ov1), .busy(bz1)
    );

    raster_scan_controller #(
        .H_PIXELS(4), .V_LINES(3), .ADDR_W(19), .DATA_W(8),
        .START_DELAY(0), .READ_LATENCY(1)
    ) dut0 (
        .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable),
        .facet_pulse(facet), .pixel_tick(tick), .clear_overrun(clr),
        .fb_address(a0), .fb_chipselect(cs0), .fb_clken(ck0),
        .fb_write(wr0), .fb_writedata(wd0), .fb_readdata(rd0),
        .laser_intensity(li0), .laser_active(la0), .line_index(ln0),
        .galvo_step(gs0), .galvo_home(gh0), .frame_done(fd0),
        .line_overrun(ov0), .busy(bz0)
    );

    // Framebuffer models: one-clock registered read, data = address[7:0]
    always @(posedge clk) begin
        if (cs1) rd1 <= a1[7:0];
        if (cs0) rd0 <= a0[7:0];
    end

    logic [18:0] m_a;
    logic        m_cs, m_ck, m_wr, m_la, m_gs, m_gh, m_fd, m_ov, m_bz;
    logic [7:0]  m_wd, m_li;
    logic [8:0]  m_ln;

    assign m_a  = sel ? a0  : a1;
    assign m_cs = sel ? cs0 : cs1;
    assign m_ck = sel ? ck0 : ck1;
    assign m_wr = sel ? wr0 : wr1;
    assign m_wd = sel ? wd0 : wd1;
    assign m_li = sel ? li0 : li1;
    assign m_la = sel ? la0 : la1;
    assign m_ln = sel ? ln0 : ln1;
    assign m_gs = sel ? gs0 : gs1;
    assign m_gh = sel ? gh0 : gh1;
    assign m_fd = sel ? fd0 : fd1;
    assign m_ov = sel ? ov0 : ov1;
    assign m_bz = sel ? bz0 : bz1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nsteps = 0;
    int nhome = 0;
    int ndone = 0;
    int home_step = 0;
    ent_t q_rd[$];
    ent_t q_lz[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        ent_t h;
        if (m_cs) begin
            if (q_rd.size() == 0) begin
                chk("cs_extra", {31'd0, m_cs}, 32'd0);
            end else begin
                h = q_rd.pop_front();
                chk("rd_addr", {13'd0, m_a}, h.a);
                chk("rd_edge", cyc, h.e);
                q_lz.push_back('{h.a & 8'hff, cyc + 2});
            end
        end
        if (q_lz.size() != 0 && q_lz[0].e == cyc) begin
            h = q_lz.pop_front();
            chk("laser_val", {24'd0, m_li}, h.a);
            chk("laser_act", {31'd0, m_la}, 32'd1);
        end
        if (m_gs) begin
            nsteps++;
            chk("done_eq_home", {31'd0, m_fd}, {31'd0, m_gh});
        end
        if (m_gh) begin
            nhome++;
            home_step = nsteps;
            chk("home_with_step", {31'd0, m_gs}, 32'd1);
        end
        if (m_fd) ndone++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int a);
        q_rd.push_back('{a, cyc + 1});
    endtask

    task automatic do_tick(input bit rd, input int a);
        tick = 1'b1;
        if (rd) push(a);
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic en);
        @(negedge clk);
        rst_n = 1'b0;
        enable = en;
        facet = 1'b0;
        tick = 1'b0;
        clr = 1'b0;
        q_rd.delete();
        q_lz.delete();
        step(2);
        nsteps = 0;
        nhome = 0;
        ndone = 0;
        home_step = 0;
        rst_n = 1'b1;
    endtask

    // mode 1: facet mid-ACTIVE, 2: drop enable after 2nd read,
    // 3: facet and clear together while in DELAY
    task automatic run_line(input int base, input int mode);
        facet = 1'b1;
        @(negedge clk);
        facet = 1'b0;
        if (mode == 3) begin
            facet = 1'b1;
            clr = 1'b1;
            @(negedge clk);
            facet = 1'b0;
            clr = 1'b0;
            chk("ovr_set_wins", {31'd0, m_ov}, 32'd1);
        end
        repeat (2) do_tick(1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            do_tick(1'b1, base + i);
            if (mode == 1 && i == 0) begin
                facet = 1'b1;
                @(negedge clk);
                facet = 1'b0;
            end
            if (mode == 2 && i == 1) enable = 1'b0;
        end
        step(6);
        chk("rd_q_empty", q_rd.size(), 0);
        chk("lz_q_empty", q_lz.size(), 0);
    endtask

    initial begin
        // reset state with enable held
        sel = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        step(1);
        chk("rst_addr", {13'd0, m_a}, 0);
        chk("rst_cs", {31'd0, m_cs}, 0);
        chk("rst_clken", {31'd0, m_ck}, 1);
        chk("rst_wr", {31'd0, m_wr}, 0);
        chk("rst_wd", {24'd0, m_wd}, 0);
        chk("rst_laser", {23'd0, m_la, m_li}, 0);
        chk("rst_line", {23'd0, m_ln}, 0);
        chk("rst_flags", {27'd0, m_gs, m_gh, m_fd, m_ov, m_bz}, 0);
        rst_n = 1'b1;
        step(2);
        chk("busy_run", {31'd0, m_bz}, 1);

        // full frame of three lines then wrap
        run_line(0, 0);
        chk("line_idx1", {23'd0, m_ln}, 1);
        chk("steps1", nsteps, 1);
        chk("blank_after", {23'd0, m_la, m_li}, 0);
        run_line(4, 0);
        run_line(8, 0);
        chk("steps3", nsteps, 3);
        chk("homes", nhome, 1);
        chk("home_at", home_step, 3);
        chk("dones", ndone, 1);
        chk("line_wrap", {23'd0, m_ln}, 0);
        run_line(0, 0);
        chk("steps4", nsteps, 4);

        // overrun set, clear, set-wins
        do_reset(1'b1);
        step(2);
        run_line(0, 1);
        chk("ovr_set", {31'd0, m_ov}, 1);
        chk("ovr_steps", nsteps, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("ovr_clr", {31'd0, m_ov}, 0);
        run_line(4, 3);
        chk("ovr_held", {31'd0, m_ov}, 1);
        chk("ovr_line", {23'd0, m_ln}, 2);

        // enable dropped mid-line
        do_reset(1'b1);
        step(2);
        run_line(0, 0);
        run_line(4, 2);
        chk("drop_steps", nsteps, 2);
        chk("drop_busy", {31'd0, m_bz}, 0);
        chk("drop_line", {23'd0, m_ln}, 0);
        enable = 1'b1;
        step(2);
        run_line(0, 0);
        chk("restart_line", {23'd0, m_ln}, 1);

        // zero start delay, back-to-back ticks
        sel = 1'b1;
        do_reset(1'b1);
        step(2);
        facet = 1'b1;
        @(negedge clk);
        facet = 1'b0;
        tick = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(i);
            @(negedge clk);
        end
        tick = 1'b0;
        step(6);
        chk("b2b_rd_q", q_rd.size(), 0);
        chk("b2b_lz_q", q_lz.size(), 0);
        chk("b2b_steps", nsteps, 1);

        // async reset during DRAIN
        sel = 1'b0;
        do_reset(1'b1);
        step(2);
        facet = 1'b1;
        @(negedge clk);
        facet = 1'b0;
        repeat (2) do_tick(1'b0, 0);
        for (int i = 0; i < 3; i++) do_tick(1'b1, i);
        tick = 1'b1;
        push(3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        tick = 1'b0;
        enable = 1'b0;
        q_rd.delete();
        q_lz.delete();
        #1;
        chk("ar_cs", {31'd0, m_cs}, 0);
        chk("ar_addr", {13'd0, m_a}, 0);
        chk("ar_laser", {23'd0, m_la, m_li}, 0);
        chk("ar_flags", {27'd0, m_gs, m_gh, m_fd, m_ov, m_bz}, 0);
        step(3);
        rst_n = 1'b1;
        step(4);
        chk("ar_idle", {31'd0, m_bz}, 0);
        chk("ar_nostep", nsteps, 0);
        chk("ar_laser2", {23'd0, m_la, m_li}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
